// File: rtl/alu_cmd_sequencer.sv
// Issue/capture wrapper around an external combinational ALU: registers accepted
// commands into the ALU, captures results into a response FIFO, and keeps a forwarded accumulator.
module alu_cmd_sequencer #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_a,
   input  logic [WIDTH-1:0] cmd_b,
   input  logic             cmd_use_acc,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [2:0]       alu_op,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_zero,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_zero,
   output logic             rsp_illegal,
   output logic [WIDTH-1:0] acc
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;

   logic             issue_vld_q;
   logic             illegal_q;
   logic [WIDTH-1:0] alu_a_q;
   logic [WIDTH-1:0] alu_b_q;
   logic [2:0]       alu_op_q;
   logic [WIDTH-1:0] acc_q;
   logic [WIDTH-1:0] acc_d;

   logic [WIDTH-1:0] res_mem_q [DEPTH];
   logic             zero_mem_q [DEPTH];
   logic             ill_mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;

   logic accept;
   logic push;
   logic pop;

   // Ready only counts slots already owned by the FIFO or the op in flight, so
   // every issued op is guaranteed a slot at capture time.
   assign cmd_ready = rst_n && ((count_q + CW'(issue_vld_q)) < CW'(DEPTH));
   assign accept    = cmd_valid && cmd_ready;
   assign push      = issue_vld_q;
   assign pop       = rsp_ready && (count_q != '0);

   always_comb begin
      acc_d    = acc_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q + CW'(push) - CW'(pop);
      // acc_d doubles as the forwarded accumulator for a chained op issued this cycle.
      if (issue_vld_q && !illegal_q) begin
         acc_d = alu_result;
      end
      if (push) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         issue_vld_q <= 1'b0;
         illegal_q   <= 1'b0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_op_q    <= '0;
         acc_q       <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            res_mem_q[i]  <= '0;
            zero_mem_q[i] <= 1'b0;
            ill_mem_q[i]  <= 1'b0;
         end
      end else begin
         issue_vld_q <= accept;
         if (accept) begin
            alu_a_q   <= cmd_use_acc ? acc_d : cmd_a;
            alu_b_q   <= cmd_b;
            alu_op_q  <= cmd_op;
            illegal_q <= (cmd_op == 3'b111);
         end
         if (push) begin
            res_mem_q[wr_ptr_q]  <= alu_result;
            zero_mem_q[wr_ptr_q] <= alu_zero;
            ill_mem_q[wr_ptr_q]  <= illegal_q;
         end
         acc_q    <= acc_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign alu_a       = alu_a_q;
   assign alu_b       = alu_b_q;
   assign alu_op      = alu_op_q;
   assign acc         = acc_q;
   assign rsp_valid   = (count_q != '0);
   assign rsp_result  = res_mem_q[rd_ptr_q];
   assign rsp_zero    = zero_mem_q[rd_ptr_q];
   assign rsp_illegal = ill_mem_q[rd_ptr_q];

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer with a behavioural ALU attached.
module tb_alu_cmd_sequencer;

   localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, OR_ = 3'b011;
   localparam logic [2:0] XOR_ = 3'b100, SLL = 3'b101, SRL = 3'b110, ILL = 3'b111;

   logic       clk, rst_n;
   logic       cmd_valid, cmd_ready, cmd_use_acc;
   logic [2:0] cmd_op, alu_op;
   logic [7:0] cmd_a, cmd_b, alu_a, alu_b, alu_result, rsp_result, acc;
   logic       alu_zero, rsp_valid, rsp_ready, rsp_zero, rsp_illegal;

   typedef struct packed {
      logic [7:0] r;
      logic       z;
      logic       il;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   pops   = 0;

   alu_cmd_sequencer #(.WIDTH(8), .DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .alu_result(alu_result), .alu_zero(alu_zero),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
      .rsp_zero(rsp_zero), .rsp_illegal(rsp_illegal), .acc(acc)
   );

   always_comb begin
      case (alu_op)
         ADD:     alu_result = alu_a + alu_b;
         SUB:     alu_result = alu_a - alu_b;
         AND_:    alu_result = alu_a & alu_b;
         OR_:     alu_result = alu_a | alu_b;
         XOR_:    alu_result = alu_a ^ alu_b;
         SLL:     alu_result = alu_a << alu_b[2:0];
         SRL:     alu_result = alu_a >> alu_b[2:0];
         default: alu_result = 8'h00;
      endcase
      alu_zero = (alu_result == 8'h00);
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Monitor: a pop happens at the next posedge whenever valid&&ready here.
   always @(negedge clk) begin
      if (rst_n && rsp_valid && rsp_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rsp_unexpected: got result=%02h zero=%0b illegal=%0b with empty scoreboard",
                     rsp_result, rsp_zero, rsp_illegal);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            pops++;
            if (rsp_result !== e.r || rsp_zero !== e.z || rsp_illegal !== e.il) begin
               errors++;
               $display("FAIL rsp: got result=%02h zero=%0b illegal=%0b expected result=%02h zero=%0b illegal=%0b",
                        rsp_result, rsp_zero, rsp_illegal, e.r, e.z, e.il);
            end else begin
               $display("rsp result=%02h zero=%0b illegal=%0b ok", rsp_result, rsp_zero, rsp_illegal);
            end
         end
      end
   end

   // Offer one command; returns 1ns after the accepting posedge.
   task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic ua, input logic [7:0] er);
      int w;
      cmd_op = op; cmd_a = a; cmd_b = b; cmd_use_acc = ua; cmd_valid = 1'b1;
      w = 0;
      @(negedge clk);
      while (!cmd_ready && w < 100) begin
         @(negedge clk);
         w++;
      end
      if (!cmd_ready) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: cmd_ready stayed 0 for op=%0d a=%02h b=%02h", op, a, b);
      end else begin
         exp_q.push_back('{er, (er == 8'h00), (op == ILL)});
         $display("cmd op=%0d a=%02h b=%02h use_acc=%0b expect=%02h", op, a, b, ua, er);
      end
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   task automatic drain();
      int w;
      rsp_ready = 1'b1;
      w = 0;
      while ((exp_q.size() != 0 || rsp_valid) && w < 50) begin
         @(posedge clk);
         #1;
         w++;
      end
      chk("drain_queue_empty", exp_q.size(), 0);
      chk("drain_rsp_valid", rsp_valid, 0);
   endtask

   logic [7:0] a3 [6] = '{8'h00, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
   logic [7:0] e3 [6] = '{8'h01, 8'h11, 8'h21, 8'h31, 8'h41, 8'h51};

   initial begin
      int accepted;
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 3'b000; cmd_a = 8'h00; cmd_b = 8'h00;
      cmd_use_acc = 1'b0; rsp_ready = 1'b0;

      // Reset state
      #12;
      chk("reset_cmd_ready", cmd_ready, 0);
      chk("reset_rsp_valid", rsp_valid, 0);
      chk("reset_acc", acc, 0);
      chk("reset_alu_a", alu_a, 0);
      chk("reset_alu_op", alu_op, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("post_reset_cmd_ready", cmd_ready, 1);
      @(posedge clk);
      #1;

      // 1: single ADD with latency check
      rsp_ready = 1'b1;
      send(ADD, 8'h05, 8'h03, 1'b0, 8'h08);
      chk("t1_rsp_valid_n", rsp_valid, 0);
      @(posedge clk);
      #1;
      chk("t1_rsp_valid_n1", rsp_valid, 1);
      chk("t1_acc", acc, 8'h08);
      drain();

      // 2: forwarded chain
      send(ADD, 8'h10, 8'h01, 1'b0, 8'h11);
      send(SUB, 8'hEE, 8'h11, 1'b1, 8'h00);
      drain();
      chk("t2_acc", acc, 8'h00);

      // 3: back-pressure fills the FIFO after 4 accepts
      rsp_ready = 1'b0;
      accepted = 0;
      for (int i = 0; i < 6; i++) begin
         cmd_op = ADD; cmd_a = a3[i]; cmd_b = 8'h01; cmd_use_acc = 1'b0; cmd_valid = 1'b1;
         @(negedge clk);
         if (cmd_ready) begin
            accepted++;
            exp_q.push_back('{e3[i], 1'b0, 1'b0});
            $display("cmd op=0 a=%02h b=01 use_acc=0 expect=%02h", a3[i], e3[i]);
         end
         @(posedge clk);
         #1;
      end
      cmd_valid = 1'b0;
      chk("t3_accepts", accepted, 4);
      chk("t3_ready_low", cmd_ready, 0);
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("t3_ready_before_pop", cmd_ready, 0);
      @(posedge clk);
      #1;
      chk("t3_ready_after_pop", cmd_ready, 1);
      drain();

      // 4: full FIFO with simultaneous push/pop, mixed ops
      rsp_ready = 1'b0;
      send(AND_, 8'hF0, 8'h3C, 1'b0, 8'h30);
      send(OR_,  8'h0F, 8'h30, 1'b0, 8'h3F);
      send(XOR_, 8'hFF, 8'h0F, 1'b0, 8'hF0);
      send(SLL,  8'h81, 8'h01, 1'b0, 8'h02);
      @(posedge clk);
      #1;
      chk("t4_full_ready", cmd_ready, 0);
      pops = 0;
      rsp_ready = 1'b1;
      send(SRL, 8'h80, 8'h07, 1'b0, 8'h01);
      send(SUB, 8'h00, 8'h01, 1'b0, 8'hFF);
      send(SLL, 8'h01, 8'h0F, 1'b0, 8'h80);
      send(ADD, 8'h80, 8'h80, 1'b0, 8'h00);
      send(XOR_, 8'hAA, 8'h55, 1'b0, 8'hFF);
      drain();
      chk("t4_pop_count", pops, 9);

      // 5: illegal op leaves the accumulator alone
      send(ADD, 8'h40, 8'h02, 1'b0, 8'h42);
      send(ILL, 8'h12, 8'h34, 1'b0, 8'h00);
      @(posedge clk);
      #1;
      chk("t5_acc_hold", acc, 8'h42);
      drain();

      // 6: reset mid-stream, then wrap-around ADD
      rsp_ready = 1'b0;
      send(ADD, 8'h01, 8'h01, 1'b0, 8'h02);
      send(ADD, 8'h02, 8'h01, 1'b0, 8'h03);
      send(ADD, 8'h03, 8'h01, 1'b0, 8'h04);
      send(ADD, 8'h04, 8'h01, 1'b0, 8'h05);
      chk("t6_pre_rsp_valid", rsp_valid, 1);
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      chk("t6_cmd_ready", cmd_ready, 0);
      chk("t6_rsp_valid", rsp_valid, 0);
      chk("t6_rsp_result", rsp_result, 0);
      chk("t6_alu_a", alu_a, 0);
      chk("t6_alu_b", alu_b, 0);
      chk("t6_acc", acc, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b1;
      send(ADD, 8'hFF, 8'h01, 1'b0, 8'h00);
      drain();
      chk("t6_acc_wrap", acc, 8'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
